// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg -- shared types and default sizing for the two-requester bus arbiter.
// Holds the arbiter state encoding and the default data width / burst limit.
package mux_arb_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage : mux_arb_pkg

// File: rtl/mux2_bus.sv
// mux2_bus -- WIDTH-wide 2:1 data selector built from one mux cell per bit.
// i_sel = 0 passes i_a (requester 0), i_sel = 1 passes i_b (requester 1).
module mux2_bus
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    // One independent 2:1 cell per data bit, all sharing the owner select.
    for (genvar g_bit = 0; g_bit < WIDTH; g_bit++) begin : g_cell
        assign o_y[g_bit] = i_sel ? i_b[g_bit] : i_a[g_bit];
    end

endmodule : mux2_bus

// File: rtl/mux_bus_arbiter.sv
// mux_bus_arbiter -- round-robin arbiter for two burst requesters feeding one
// registered output beat stage through a 2:1 data selector.
// Optional feature: define MUX_ARB_TIMEOUT_EN to force release of the bus after
// MAX_BURST accepted beats without a last beat (pulses timeout for one cycle).
module mux_bus_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             last0,
    input  logic             last1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             timeout
);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic             r_rr;          // last served requester
    logic             r_sel;         // current / last owner
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] w_mux_data;

    logic             w_slot_free;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_beat;
    logic             w_own_req;
    logic             w_own_last;
    logic             w_release;
    logic             w_limit_hit;

    // Owner-side request/last, valid only while in an OWN state (r_sel tracks the owner there).
    assign w_own_req  = r_sel ? req1  : req0;
    assign w_own_last = r_sel ? last1 : last0;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: tie-break away from the last served requester; release on last, abort or burst limit.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        w_release    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req0 && (!req1 || r_rr)) begin
                    w_next_state = OWN0;
                end else if (req1) begin
                    w_next_state = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!w_own_req || (w_beat && (w_own_last || w_limit_hit))) begin
                    w_next_state = IDLE;
                    w_release    = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output logic: grant the owner whenever the output stage can take a beat.
    always_comb begin
        w_slot_free = !r_out_valid || out_ready;
        w_gnt0      = (r_state == OWN0) && w_slot_free;
        w_gnt1      = (r_state == OWN1) && w_slot_free;
        w_beat      = (w_gnt0 && req0) || (w_gnt1 && req1);
    end

    // Round-robin pointer and owner select; sel holds its value through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr  <= 1'b1;
            r_sel <= 1'b0;
        end else begin
            if (w_release) begin
                r_rr <= r_sel;
            end
            if (w_next_state == OWN0) begin
                r_sel <= 1'b0;
            end else if (w_next_state == OWN1) begin
                r_sel <= 1'b1;
            end
        end
    end

    mux2_bus #(
        .WIDTH (WIDTH)
    ) u_mux2_bus (
        .i_sel (r_sel),
        .i_a   (data0),
        .i_b   (data1),
        .o_y   (w_mux_data)
    );

    // Output beat register: load on an accepted beat, drain when downstream takes it.
    always_ff @(posedge clk) begin
        // NOTE: out_data is a single register, not a memory, and is reset so no stale beat survives reset.
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_beat) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_timeout;
    logic             w_force;

    // Count accepted beats of the current grant; every new grant starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_beat_cnt <= '0;
        end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    assign w_limit_hit = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    assign w_force     = w_beat && !w_own_last && w_limit_hit;

    // Timeout pulse lines up with the IDLE cycle that follows a forced release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
        end
    end

    assign timeout = r_timeout;
`else
    // Bursts are unbounded in this build; an out-of-range limit still gets its own (empty) scope.
    if (MAX_BURST < 1) begin : g_max_burst_unused
    end

    assign w_limit_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign sel       = r_sel;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule : mux_bus_arbiter

// File: doc/mux_bus_arbiter.md
MUX_BUS_ARBITER -- requirements
Module: mux_bus_arbiter

Interface
REQ-001 Parameter SHALL be: WIDTH, 8, data bits per beat.
REQ-002 Parameter SHALL be: MAX_BURST, 4, beats per grant before forced release (used only with MUX_ARB_TIMEOUT_EN).
REQ-003 Port SHALL be: clk  input  1  single clock, all state on rising edge.
REQ-004 Port SHALL be: rst  input  1  reset, synchronous and active-high.
REQ-005 Port SHALL be: req0 / req1  input  1  requester 0/1 wants the bus; a beat is offered while high.
REQ-006 Port SHALL be: last0 / last1  input  1  offered beat is final beat of burst.
REQ-007 Port SHALL be: data0 / data1  input  WIDTH  offered beat data.
REQ-008 Port SHALL be: gnt0 / gnt1  output  1  beat accepted this cycle when req_i & gnt_i.
REQ-009 Port SHALL be: sel  output  1  current/last owner; drives 2:1 data selector select (0 = requester 0).
REQ-010 Port SHALL be: out_valid  output  1  out_data holds a beat.
REQ-011 Port SHALL be: out_data  output  WIDTH  registered selected beat.
REQ-012 Port SHALL be: out_ready  input  1  downstream accepts beat when out_valid & out_ready.
REQ-013 Port SHALL be: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-014 FSM SHALL have states IDLE, OWN0, OWN1, plus round-robin pointer rr (last served requester).
REQ-015 IDLE: only req_i high -> OWN_i next cycle; both high -> OWN to requester != rr; none -> stay IDLE.
REQ-016 gnt_i SHALL be (state==OWN_i) & (!out_valid | out_ready); gnt in IDLE SHALL be 0; gnt0 & gnt1 never both 1.
REQ-017 Accepted beat SHALL load out_data <= data_i and set out_valid next cycle; out_valid clears on out_ready with no new beat.
REQ-018 Latency: req_i rising in IDLE at cycle N -> gnt_i at N+1 -> out_valid at N+2 (out_ready held high).
REQ-019 Throughput: one beat per cycle while owner holds req and out_ready=1.
REQ-020 Accepted beat with last_i=1 -> IDLE next cycle, rr <= i.
REQ-021 Owner drops req_i without last (abort) -> IDLE next cycle, rr <= i, no beat issued.
REQ-022 sel SHALL be 1 in OWN1, 0 in OWN0, hold previous value in IDLE.
REQ-023 Stall: out_valid=1, out_ready=0 -> gnt low, out_data/out_valid stable, state held.
REQ-024 Non-owner req ignored until owner releases; re-arbitration costs exactly one IDLE cycle.

Reset
REQ-025 rst=1 at a clock edge SHALL force: state IDLE, rr=1 (requester 0 wins first tie), sel=0, gnt0=gnt1=0, out_valid=0, out_data=0, timeout=0, beat counter=0.
REQ-026 Reset mid-burst SHALL discard the in-flight and registered beat; no output beat after reset until a new grant.

Configuration
REQ-027 Macro MUX_ARB_TIMEOUT_EN defined: beat counter counts accepted beats per grant; MAX_BURST-th beat with last=0 -> IDLE next cycle, rr <= owner, timeout pulses 1 cycle.
REQ-028 Macro undefined: no counter, burst unbounded, timeout tied 0.

Structure
REQ-029 Package mux_arb_pkg SHALL hold the state enum typedef and WIDTH/MAX_BURST defaults.
REQ-030 Sub-module mux2_bus (WIDTH-wide 2:1 selector of per-bit mux cells, select = owner) SHALL feed out_data register.

Verification
REQ-031 req0 only, 3 beats 0x11,0x22,0x33 (last on 0x33), out_ready=1 -> out_data 0x11..0x33 on cycles N+2..N+4, IDLE at N+4, rr=0.
REQ-032 req0,req1 both high from reset -> gnt0 first; after its last beat, one IDLE cycle, then gnt1, sel=1.
REQ-033 Owner 1 streaming 0xA5, out_ready=0 for 3 cycles -> gnt1=0, out_data=0xA5 stable, no beat lost.
REQ-034 MUX_ARB_TIMEOUT_EN, MAX_BURST=4, req0 6 beats no last, req1 waiting -> release after 4th beat, timeout pulse, gnt1 next grant.
REQ-035 rst asserted during OWN1 with out_valid=1 -> next cycle out_valid=0, gnt0=gnt1=0, sel=0, state IDLE.
REQ-036 Owner 0 drops req0 mid-burst without last -> IDLE next cycle, no extra beat, pending req1 granted.
